// File: rtl/wide_word_serializer.sv
// Wide-to-narrow serializer: takes one DATA_WIDTH-bit entry per handshake and streams it out
// as CHUNK_WIDTH-bit beats, least-significant chunk first, with a chunk index and last flag.
module wide_word_serializer #(
    parameter  int DATA_WIDTH  = 113,
    parameter  int CHUNK_WIDTH = 32,
    localparam int NUM_CHUNKS  = (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH,
    localparam int IDX_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHUNK_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last
);

    localparam int              PAD_W    = NUM_CHUNKS * CHUNK_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                                state;
    logic [IDX_W-1:0]                      idx;
    logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0] entry;

    logic sending;
    logic at_last;
    logic consume;
    logic accept;

    // Outputs are forced to zero during reset so nothing stale leaks before the first clock edge.
    assign sending   = !rst && (state == SEND);
    assign at_last   = (idx == LAST_IDX);
    assign consume   = sending && out_ready;
    assign accept    = in_valid && in_ready;

    assign out_valid = sending;
    assign out_last  = sending && at_last;
    assign out_idx   = sending ? idx : '0;
    assign out_data  = sending ? entry[idx] : '0;

    // A new entry may enter during the final beat's handshake, which keeps the stream bubble-free.
    assign in_ready  = !rst && ((state == IDLE) || (sending && out_ready && at_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            entry <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        entry <= PAD_W'(in_data);
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (consume) begin
                        if (!at_last) begin
                            idx <= idx + IDX_W'(1);
                        end else begin
                            idx <= '0;
                            if (accept) begin
                                entry <= PAD_W'(in_data);
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_word_serializer.sv
// Scoreboard bench for wide_word_serializer: directed scenarios plus a randomized round trip,
// with a second single-chunk instance for the NUM_CHUNKS==1 case.
module tb_wide_word_serializer;

    localparam int DW = 113;
    localparam int CW = 32;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_data;
    logic [1:0]    out_idx;
    logic          out_last;

    logic          s_in_valid;
    logic          s_in_ready;
    logic [31:0]   s_in_data;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [31:0]   s_out_data;
    logic [0:0]    s_out_idx;
    logic          s_out_last;

    always #5 clk = ~clk;

    wide_word_serializer #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
    );

    wide_word_serializer #(.DATA_WIDTH(32), .CHUNK_WIDTH(32)) dut_single (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_idx(s_out_idx), .out_last(s_out_last)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [1:0]  idx;
        logic        last;
    } cap_t;

    beat_t exp_q[$];
    cap_t  got[$];
    int    cyc = 0;
    int    acc_cyc = 0;
    int    pass_cnt = 0;
    int    check_cnt = 0;
    logic  rnd_done;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        check_cnt++;
        $display("[TB] FAIL %s: condition not reached, expected it within the cycle budget", name);
    endtask

    task automatic pushEntry(input logic [DW-1:0] d);
        logic [127:0] ext;
        beat_t        b;
        ext = 128'(d);
        for (int k = 0; k < NC; k++) begin
            b.data = ext[k*32 +: 32];
            b.idx  = 2'(k);
            b.last = (k == NC - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one entry and holds it until the handshake; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [DW-1:0] d);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) failNow("accept_timeout");
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic waitIdx(input logic [1:0] v);
        int n;
        n = 0;
        while (!(out_valid === 1'b1 && out_idx === v) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) failNow("wait_idx_timeout");
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: consumes every beat the DUT hands over and matches it against the expected queue.
    initial begin
        beat_t       e;
        logic        hold_pend;
        logic [31:0] hold_data;
        logic [1:0]  hold_idx;
        logic        hold_last;
        hold_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    checkOutput("hold_valid", 128'(out_valid), 128'(1'b1));
                    checkOutput("hold_data", 128'(out_data), 128'(hold_data));
                    checkOutput("hold_idx", 128'(out_idx), 128'(hold_idx));
                    checkOutput("hold_last", 128'(out_last), 128'(hold_last));
                end
                hold_pend = out_valid && !out_ready;
                hold_data = out_data;
                hold_idx  = out_idx;
                hold_last = out_last;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_cnt++;
                        $display("[TB] FAIL spurious_beat: got idx %0d data %h, expected no beat", out_idx, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat_data", 128'(out_data), 128'(e.data));
                        checkOutput("beat_idx", 128'(out_idx), 128'(e.idx));
                        checkOutput("beat_last", 128'(out_last), 128'(e.last));
                    end
                    got.push_back('{cyc, out_data, out_idx, out_last});
                end
                if (in_valid && in_ready) begin
                    acc_cyc = cyc;
                    pushEntry(in_data);
                end
            end
        end
    end

    initial begin
        logic [31:0]   basic_exp [4];
        logic [127:0]  r;
        int            a;
        int            n;

        basic_exp   = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'h00012345};
        rst         = 1'b1;
        in_valid    = 1'b1;
        in_data     = '1;
        out_ready   = 1'b1;
        s_in_valid  = 1'b1;
        s_in_data   = 32'hFFFFFFFF;
        s_out_ready = 1'b1;
        rnd_done    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 128'(in_ready), 128'(1'b0));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("rst_out_data", 128'(out_data), 128'(0));
        checkOutput("rst_out_idx", 128'(out_idx), 128'(0));
        checkOutput("rst_out_last", 128'(out_last), 128'(1'b0));
        checkOutput("rst_single_in_ready", 128'(s_in_ready), 128'(1'b0));
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", 128'(in_ready), 128'(1'b1));
        checkOutput("idle_out_valid", 128'(out_valid), 128'(1'b0));
        idle(1);

        $display("[TB] basic transfer");
        got.delete();
        applyStimulus({17'h12345, 32'hA0000002, 32'hA0000001, 32'hA0000000});
        a = acc_cyc;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("basic_in_ready_low", 128'(in_ready), 128'(1'b0));
        end
        idle(3);
        checkOutput("basic_beat_count", 128'(got.size()), 128'(4));
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            checkOutput("basic_data", 128'(got[k].data), 128'(basic_exp[k]));
            checkOutput("basic_idx", 128'(got[k].idx), 128'(k));
            checkOutput("basic_last", 128'(got[k].last), 128'(k == 3));
            checkOutput("basic_latency", 128'(got[k].cyc), 128'(a + 1 + k));
        end

        $display("[TB] backpressure");
        got.delete();
        applyStimulus({17'h1ABCD, 32'h33333333, 32'h22222222, 32'h11111111});
        waitIdx(2'd1);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_valid", 128'(out_valid), 128'(1'b1));
            checkOutput("bp_data", 128'(out_data), 128'(32'h22222222));
            checkOutput("bp_idx", 128'(out_idx), 128'(1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(5);
        checkOutput("bp_beat_count", 128'(got.size()), 128'(4));
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            checkOutput("bp_idx_seq", 128'(got[k].idx), 128'(k));
        end
        if (got.size() == 4) begin
            checkOutput("bp_resume_data", 128'(got[2].data), 128'(32'h33333333));
            checkOutput("bp_final_data", 128'(got[3].data), 128'(32'h0001ABCD));
        end

        $display("[TB] back-to-back");
        got.delete();
        applyStimulus({17'h00007, 32'h30000002, 32'h30000001, 32'h30000000});
        waitIdx(2'd3);
        in_valid = 1'b1;
        in_data  = {17'h1FFFF, 32'h40000002, 32'h40000001, 32'h40000000};
        @(negedge clk);
        checkOutput("b2b_in_ready", 128'(in_ready), 128'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(7);
        checkOutput("b2b_beat_count", 128'(got.size()), 128'(8));
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            checkOutput("b2b_idx_seq", 128'(got[k].idx), 128'(k % 4));
            checkOutput("b2b_cycle", 128'(got[k].cyc), 128'(got[0].cyc + k));
        end
        if (got.size() == 8) begin
            checkOutput("b2b_second_first", 128'(got[4].data), 128'(32'h40000000));
            checkOutput("b2b_second_pad", 128'(got[7].data), 128'(32'h0001FFFF));
        end

        $display("[TB] reset mid-entry");
        applyStimulus({17'h00055, 32'h50000002, 32'h50000001, 32'h50000000});
        waitIdx(2'd2);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("midrst_out_last", 128'(out_last), 128'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_out_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("postrst_in_ready", 128'(in_ready), 128'(1'b1));
        idle(1);
        got.delete();
        applyStimulus({17'h00066, 32'h60000002, 32'h60000001, 32'h60000000});
        idle(6);
        checkOutput("postrst_beat_count", 128'(got.size()), 128'(4));
        if (got.size() == 4) begin
            checkOutput("postrst_first_idx", 128'(got[0].idx), 128'(0));
            checkOutput("postrst_first_data", 128'(got[0].data), 128'(32'h60000000));
            checkOutput("postrst_last_data", 128'(got[3].data), 128'(32'h00000066));
        end

        $display("[TB] single chunk");
        s_in_valid = 1'b1;
        s_in_data  = 32'hDEADBEEF;
        @(negedge clk);
        checkOutput("single_accept_ready", 128'(s_in_ready), 128'(1'b1));
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        s_in_data  = 32'h0;
        @(negedge clk);
        checkOutput("single_valid", 128'(s_out_valid), 128'(1'b1));
        checkOutput("single_data", 128'(s_out_data), 128'(32'hDEADBEEF));
        checkOutput("single_last", 128'(s_out_last), 128'(1'b1));
        checkOutput("single_idx", 128'(s_out_idx), 128'(0));
        checkOutput("single_in_ready_last", 128'(s_in_ready), 128'(1'b1));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("single_in_ready_after", 128'(s_in_ready), 128'(1'b1));
        checkOutput("single_valid_after", 128'(s_out_valid), 128'(1'b0));
        idle(1);

        $display("[TB] random round trip");
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    r = {$urandom, $urandom, $urandom, $urandom};
                    applyStimulus(r[DW-1:0]);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        checkOutput("drain_empty", 128'(exp_q.size()), 128'(0));
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
